// File: rtl/abro_pkg.sv
// abro_pkg: shared definitions for the ABRO sequencing controller.
// Holds the 2-bit state type and its four fixed encodings.
// The encoding doubles as a {B seen, A seen} flag pair, which makes the
// debug state output readable directly on a waveform.
package abro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GOT_A = 2'b01,
    GOT_B = 2'b10,
    DONE  = 2'b11
  } abro_state_t;

endpackage

// File: rtl/abro_state_machine.sv
// abro_state_machine: classic ABRO controller. Waits for events A and B
// (in either order or together), emits a single-cycle pulse on O, then
// stays silent until reset re-arms it.
//
// Ports:
//   clk    in   1  rising-edge clock
//   reset  in   1  asynchronous active-high reset (the R of ABRO)
//   A      in   1  event A, level-sampled each edge
//   B      in   1  event B, level-sampled each edge
//   O      out  1  registered pulse, high only in the first DONE cycle
//   state  out  2  current state register (debug)
//
// Build option: define ABRO_AUTO_REARM_EN to make DONE last one cycle and
// fall back to IDLE, so a new A/B pair can be detected without reset.
//
// state | meaning
// ------+-----------------------------------------
// IDLE  | no event seen
// GOT_A | A seen, waiting for B
// GOT_B | B seen, waiting for A
// DONE  | both seen, O already emitted
module abro_state_machine
  import abro_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       A,
  input  logic       B,
  output logic       O,
  output logic [1:0] state
);

  abro_state_t r_state;
  abro_state_t w_next;
  logic        r_o;
  logic        w_o_next;

  always_comb begin
    w_next = IDLE;
    case (r_state)
      IDLE: begin
        if (A && B) w_next = DONE;
        else if (A) w_next = GOT_A;
        else if (B) w_next = GOT_B;
        else        w_next = IDLE;
      end
      GOT_A:   w_next = B ? DONE : GOT_A;
      GOT_B:   w_next = A ? DONE : GOT_B;
`ifdef ABRO_AUTO_REARM_EN
      DONE:    w_next = IDLE;
`else
      DONE:    w_next = DONE;
`endif
      // Unknown values (e.g. X after power-up glitches) recover to IDLE.
      default: w_next = IDLE;
    endcase
  end

  // O is registered alongside the state: high only on entry into DONE.
  assign w_o_next = (w_next == DONE) && (r_state != DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_o     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_o     <= w_o_next;
    end
  end

  assign O     = r_o;
  assign state = r_state;

endmodule

// File: tb/tb_abro_state_machine.sv
// Bench for abro_state_machine. The reference model tracks "A seen" and
// "B seen" flags; expected {state, O} is queued when inputs are driven and
// popped after the sampling edge.
module tb_abro_state_machine;

  logic       clk;
  logic       reset;
  logic       A;
  logic       B;
  logic       O;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  logic [2:0] exp_q[$];
  logic       m_sa;
  logic       m_sb;

  abro_state_machine dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .O     (O),
    .state (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic pop_and_check(input string tag);
    logic [2:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s: observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, ".state"}, state, e[2:1]);
      check({tag, ".O"}, {1'b0, O}, {1'b0, e[0]});
    end
  endtask

  // Drive one cycle of inputs, advance the model, check after the edge.
  task automatic step(input string tag, input logic a, input logic b);
    logic done_before;
    @(negedge clk);
    A = a;
    B = b;
    done_before = m_sa && m_sb;
`ifdef ABRO_AUTO_REARM_EN
    if (done_before) begin
      m_sa = 1'b0;
      m_sb = 1'b0;
    end else begin
      m_sa = m_sa | a;
      m_sb = m_sb | b;
    end
`else
    m_sa = m_sa | a;
    m_sb = m_sb | b;
`endif
    exp_q.push_back({m_sb, m_sa, (m_sa && m_sb && !done_before)});
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  // Assert reset between edges and check that outputs clear without a clock.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b1;
    m_sa = 1'b0;
    m_sb = 1'b0;
    exp_q.push_back(3'b000);
    #1;
    pop_and_check(tag);
    @(negedge clk);
    A = 1'b0;
    B = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    A = 1'b0;
    B = 1'b0;
    m_sa = 1'b0;
    m_sb = 1'b0;

    // Reset held across an edge with events asserted: must stay IDLE.
    @(negedge clk);
    A = 1'b1;
    B = 1'b1;
    exp_q.push_back(3'b000);
    @(posedge clk);
    #1;
    pop_and_check("reset_hold");
    @(negedge clk);
    A = 1'b0;
    B = 1'b0;
    reset = 1'b0;

    // A then B
    step("ab_a", 1'b1, 1'b0);
    step("ab_gap", 1'b0, 1'b0);
    step("ab_b", 1'b0, 1'b1);
    step("ab_after", 1'b0, 1'b0);
    step("ab_rep_a", 1'b1, 1'b0);
    step("ab_rep_b", 1'b0, 1'b1);
    step("ab_rep_ab", 1'b1, 1'b1);

    // B then A
    async_reset("rst_ba");
    step("ba_b", 1'b0, 1'b1);
    step("ba_b_hold", 1'b0, 1'b1);
    step("ba_a", 1'b1, 1'b0);
    step("ba_after", 1'b0, 1'b0);

    // Simultaneous, held high
    async_reset("rst_sim");
    step("sim_1", 1'b1, 1'b1);
    step("sim_2", 1'b1, 1'b1);
    step("sim_3", 1'b1, 1'b1);
    step("sim_4", 1'b0, 1'b0);

    // Reset while O is high must clear O asynchronously
    async_reset("rst_pre_o");
    step("o_rise", 1'b1, 1'b1);
    async_reset("rst_during_o");

    // Mid-sequence reset, then B alone goes to GOT_B
    step("mid_a", 1'b1, 1'b0);
    async_reset("rst_mid");
    step("mid_b", 1'b0, 1'b1);
    step("mid_idle", 1'b0, 1'b0);

    // Random soak
    async_reset("rst_soak");
    for (int i = 0; i < 20; i++) begin
      step("soak", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Second pair after completion (rearm build gives a second pulse)
    async_reset("rst_pair");
    step("p1_a", 1'b1, 1'b0);
    step("p1_b", 1'b0, 1'b1);
    step("p1_next", 1'b0, 1'b0);
    step("p2_a", 1'b1, 1'b0);
    step("p2_b", 1'b0, 1'b1);
    step("p2_next", 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
